calc1_port_responder: RTL and testbench
=======================================

Name: calc1_port_responder

Overview:
- Synthesizable model of one calc1 request/response port; it is the responder end of the calc1 port protocol that the calc1 benches drive as initiator.
- Captures a two-cycle request (command + operand1, then operand2), executes add/sub/shift, and returns a one-cycle response with result.
- Serves as a golden reference DUT and bench loopback for the calc1 black box.
- One outstanding request per port, as on calc1.

Parameters:
- DATA_W, 32, operand/result width.
- RESP_LATENCY, 1, cycles from operand2 cycle to response cycle; legal range 1..15.

Ports:
- c_clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_cmd_in  in  4  command: 0 none, 1 add, 2 sub, 5 shift left, 6 shift right; all others invalid.
- req_data_in  in  DATA_W  operand1 in command cycle, operand2 in following cycle.
- out_resp  out  2  0 none, 1 success, 2 overflow/underflow/invalid command; 3 never driven.
- out_data  out  DATA_W  result; valid only when out_resp != 0, else 0.
- busy  out  1  request outstanding; initiator must not issue a new command.
- proto_err  out  1  present only with CALC1_PROTOCOL_CHECK_EN.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; out_resp=0, out_data=0, busy=0, proto_err=0; latency counter and operand registers cleared. Reset mid-request discards it, and no response is ever produced for it.
- FSM IDLE -> OP2 -> WAIT -> IDLE.
- IDLE: on req_cmd_in != 0, latch cmd and operand1, go to OP2, busy=1.
- OP2: latch req_data_in as operand2 unconditionally; req_cmd_in is ignored this cycle. Compute result via ALU, load counter with RESP_LATENCY-1, go to WAIT.
- WAIT: decrement counter. When it is 0, register the response so out_resp/out_data are nonzero for exactly the cycle RESP_LATENCY after the OP2 cycle. Return to IDLE with busy=0 that same cycle.
- With default latency: cmd at edge k, operand2 at edge k+1, response visible after edge k+2.
- A new command is accepted in IDLE only; the earliest acceptance is the cycle the response is driven.
- Commands arriving in OP2/WAIT are dropped.
- Add: 33-bit sum; carry out gives resp 2, data 0; else resp 1, data = sum.
- Sub: operand2 > operand1 gives resp 2, data 0 (underflow); else resp 1, data = difference. Equal operands give resp 1, data 0.
- Shift left/right: logical, zero fill, amount = operand2[4:0]. Always resp 1. Amount 0 returns operand1 unchanged.
- Invalid cmd (3,4,7..15): still consumes the operand2 cycle; resp 2, data 0, same latency.
- out_resp returns to 0 and out_data to 0 the cycle after a response.

Optional Feature:
- Macro CALC1_PROTOCOL_CHECK_EN.
- Defined: proto_err port exists. It pulses high for one cycle, registered, whenever req_cmd_in != 0 in OP2 or WAIT. It is a sticky-free pulse, and the dropped command is not executed.
- Undefined: port and logic are absent; such commands are silently dropped.

Decomposition:
- Package calc1_pkg holds:
  - command encodings CMD_NONE/ADD/SUB/SHL/SHR;
  - response encodings RESP_NONE/OK/ERR;
  - the state enum type;
  - DATA_W default constant.
- One sub-module, calc1_alu: purely combinational cmd + operands -> result + resp code, reused by bench checkers.
- The FSM and counter stay in calc1_port_responder.

Test Plan:
- Add 0x0000_0005 + 0x0000_0003 -> resp 1, data 0x0000_0008, two cycles after the cmd edge.
- Sub 0x0000_0001 - 0x0000_000F -> resp 2, data 0 (underflow). Sub 0xF - 0xF -> resp 1, data 0.
- Add 0xFFFF_FFFF + 0x0000_0001 -> resp 2, data 0. Add 0xFFFF_FFFE + 1 -> resp 1, data 0xFFFF_FFFF.
- Shift left 0x0000_0001 by 0x0000_0023 (amount 3) -> resp 1, data 0x0000_0008.
- Shift right 0x8000_0000 by 31 -> resp 1, data 0x0000_0001.
- Cmd 3 -> resp 2, data 0. Cmd 1 issued during WAIT with RESP_LATENCY=4 -> dropped, and proto_err pulses if enabled. Reset_n asserted in WAIT -> outputs 0 immediately, and no response follows.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1 port shared definitions: command/response encodings, FSM state type,
// and the width constants used by the responder, its ALU and the port interface.
package calc1_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CMD_W      = 4;
    localparam int unsigned RESP_W     = 2;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned CNT_W      = 4;

    localparam logic [CMD_W-1:0] CMD_NONE = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL  = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR  = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/calc1_port_responder_if.sv
// calc1 request/response port bundle.
//   req_cmd_in  : command (initiator -> responder)
//   req_data_in : operand1 in command cycle, operand2 in the following cycle
//   out_resp    : response code, nonzero for exactly one cycle
//   out_data    : result, zero whenever out_resp is zero
//   busy        : request outstanding
//   proto_err   : command seen while busy (only with CALC1_PROTOCOL_CHECK_EN)
interface calc1_port_responder_if
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [CMD_W-1:0]  req_cmd_in;
    logic [DATA_W-1:0] req_data_in;
    logic [RESP_W-1:0] out_resp;
    logic [DATA_W-1:0] out_data;
    logic              busy;
`ifdef CALC1_PROTOCOL_CHECK_EN
    logic              proto_err;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, proto_err
    );
    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, proto_err
    );
`else
    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy
    );
    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy
    );
`endif
endinterface

// File: rtl/calc1_alu.sv
// calc1 ALU: purely combinational command + operands -> response code + result.
//   cmd      : calc1 command encoding
//   op1, op2 : operands (op2[4:0] is the shift amount for shifts)
//   resp_c   : RESP_OK, or RESP_ERR for overflow/underflow/invalid command
//   result_c : result, zero whenever resp_c is not RESP_OK
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [RESP_W-1:0] resp_c,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W:0]    sum_c;
    logic [SHAMT_W-1:0] shamt_c;

    assign sum_c   = {1'b0, op1} + {1'b0, op2};
    assign shamt_c = op2[SHAMT_W-1:0];

    // Operation select; every error path returns zero data.
    always_comb begin
        resp_c   = RESP_NONE;
        result_c = '0;
        case (cmd)
            CMD_NONE: begin
                resp_c   = RESP_NONE;
            end
            CMD_ADD: begin
                if (sum_c[DATA_W]) begin
                    resp_c   = RESP_ERR;
                end else begin
                    resp_c   = RESP_OK;
                    result_c = sum_c[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    resp_c   = RESP_ERR;
                end else begin
                    resp_c   = RESP_OK;
                    result_c = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp_c   = RESP_OK;
                result_c = op1 << shamt_c;
            end
            CMD_SHR: begin
                resp_c   = RESP_OK;
                result_c = op1 >> shamt_c;
            end
            default: begin
                resp_c   = RESP_ERR;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1 port responder: captures a two-cycle request (command + operand1, then
// operand2), executes it in calc1_alu and returns a one-cycle response
// RESP_LATENCY cycles after the operand2 cycle. One outstanding request.
//   c_clk   : clock, rising edge
//   reset_n : asynchronous active-low reset (deasserted synchronously inside)
//   port    : calc1_port_responder_if.slave (request in, response/busy out)
// Optional: `define CALC1_PROTOCOL_CHECK_EN adds port.proto_err, a one-cycle
// registered pulse for every command presented while a request is outstanding.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                   c_clk,
    input  logic                   reset_n,
    calc1_port_responder_if.slave  port
);

    logic              rst_meta_n;
    logic              rst_sync_n;
    state_e            state;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] result_q;
    logic [RESP_W-1:0] alu_resp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RESP_W-1:0] resp_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic [RESP_W-1:0] alu_resp_c;
    logic [DATA_W-1:0] alu_result_c;

    // Reset synchronizer: assertion passes straight through, release is clocked.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    // Operand2 comes straight off the bus during the OP2 cycle.
    calc1_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .cmd      (cmd_q),
        .op1      (op1_q),
        .op2      (port.req_data_in),
        .resp_c   (alu_resp_c),
        .result_c (alu_result_c)
    );

`ifdef CALC1_PROTOCOL_CHECK_EN
    logic perr_q;

    // Any command while a request is outstanding is dropped and flagged.
    always_ff @(posedge c_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= (state != ST_IDLE) && (port.req_cmd_in != CMD_NONE);
        end
    end

    assign port.proto_err = perr_q;
`endif

    // Request FSM with latency counter; response is a single registered cycle.
    always_ff @(posedge c_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            op1_q      <= '0;
            result_q   <= '0;
            alu_resp_q <= RESP_NONE;
            cnt_q      <= '0;
            resp_q     <= RESP_NONE;
            data_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            resp_q <= RESP_NONE;
            data_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (port.req_cmd_in != CMD_NONE) begin
                        cmd_q  <= port.req_cmd_in;
                        op1_q  <= port.req_data_in;
                        busy_q <= 1'b1;
                        state  <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    result_q   <= alu_result_c;
                    alu_resp_q <= alu_resp_c;
                    cnt_q      <= CNT_W'(RESP_LATENCY - 1);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        resp_q <= alu_resp_q;
                        data_q <= result_q;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign port.out_resp = resp_q;
    assign port.out_data = data_q;
    assign port.busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: two instances (latency 1 and latency 4)
// against a cycle-indexed expectation table filled from arithmetic rules,
// plus hand-computed literal checks at each response cycle.
module tb_calc1_port_responder;
    import calc1_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int          MAXC = 2048;

    logic c_clk   = 1'b0;
    logic reset_n = 1'b1;

    always #5 c_clk = ~c_clk;

    calc1_port_responder_if #(.DATA_W(DW)) if0 ();
    calc1_port_responder_if #(.DATA_W(DW)) if1 ();

    calc1_port_responder #(.DATA_W(DW), .RESP_LATENCY(1)) dut0 (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .port    (if0)
    );

    calc1_port_responder #(.DATA_W(DW), .RESP_LATENCY(4)) dut1 (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .port    (if1)
    );

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    logic [1:0]  m_resp [2][MAXC];
    logic [31:0] m_data [2][MAXC];
    bit          m_busy [2][MAXC];
`ifdef CALC1_PROTOCOL_CHECK_EN
    bit          m_perr [2][MAXC];
`endif

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Expected {resp, data} from the arithmetic definition of each command.
    function automatic logic [33:0] ref_op(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned s;
        longint unsigned p;
        logic [1:0]  r;
        logic [31:0] d;
        r = 2'd2;
        d = 32'd0;
        p = 64'd1 << b[4:0];
        case (cmd)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = 32'(s); end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = 32'((64'(a) * p) % 64'h1_0000_0000); end
            4'd6: begin r = 2'd1; d = 32'(64'(a) / p); end
            default: begin r = 2'd2; d = 32'd0; end
        endcase
        return {r, d};
    endfunction

    // Record what a request accepted at edge n+1 must produce.
    task automatic model_req(input int d, input int n, input logic [3:0] cmd,
                             input logic [31:0] a, input logic [31:0] b);
        int L;
        logic [33:0] e;
        L = (d == 0) ? 1 : 4;
        e = ref_op(cmd, a, b);
        for (int t = n + 1; t <= n + 1 + L; t++) m_busy[d][t] = 1'b1;
        m_resp[d][n + 2 + L] = e[33:32];
        m_data[d][n + 2 + L] = e[31:0];
    endtask

    task automatic drive(input int d, input logic [3:0] cmd, input logic [31:0] data);
        if (d == 0) begin
            if0.req_cmd_in  = cmd;
            if0.req_data_in = data;
        end else begin
            if1.req_cmd_in  = cmd;
            if1.req_data_in = data;
        end
    endtask

    task automatic get(input int d, output logic [1:0] r, output logic [31:0] data,
                       output logic busy);
        if (d == 0) begin
            r = if0.out_resp; data = if0.out_data; busy = if0.busy;
        end else begin
            r = if1.out_resp; data = if1.out_data; busy = if1.busy;
        end
    endtask

    // Called #1 after an edge; returns #1 after the response edge.
    // drop_off (1..L) presents an extra command that many cycles after the command cycle.
    task automatic issue(input int d, input string name, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] exp_r, input logic [31:0] exp_d,
                         input int drop_off);
        int n, L;
        logic [1:0]  r;
        logic [31:0] data;
        logic        busy;
        L = (d == 0) ? 1 : 4;
        n = cyc;
        model_req(d, n, cmd, a, b);
        drive(d, cmd, a);
        for (int j = 1; j <= L + 2; j++) begin
            @(posedge c_clk);
            #1;
            drive(d, (j == drop_off) ? CMD_ADD : CMD_NONE,
                  (j == 1) ? b : ((j == drop_off) ? 32'hDEAD_0001 : 32'd0));
`ifdef CALC1_PROTOCOL_CHECK_EN
            if (j == drop_off) m_perr[d][n + j + 1] = 1'b1;
`endif
        end
        get(d, r, data, busy);
        check({name, "_resp"}, 32'(r), 32'(exp_r));
        check({name, "_data"}, data, exp_d);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge c_clk);
            #1;
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge c_clk) begin
        if (cmp_en && cyc < MAXC) begin
            check("d0_resp", 32'(if0.out_resp), 32'(m_resp[0][cyc]));
            check("d0_data", if0.out_data, m_data[0][cyc]);
            check("d0_busy", 32'(if0.busy), 32'(m_busy[0][cyc]));
            check("d1_resp", 32'(if1.out_resp), 32'(m_resp[1][cyc]));
            check("d1_data", if1.out_data, m_data[1][cyc]);
            check("d1_busy", 32'(if1.busy), 32'(m_busy[1][cyc]));
`ifdef CALC1_PROTOCOL_CHECK_EN
            check("d0_perr", 32'(if0.proto_err), 32'(m_perr[0][cyc]));
            check("d1_perr", 32'(if1.proto_err), 32'(m_perr[1][cyc]));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 2048", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < MAXC; t++) begin
                m_resp[d][t] = 2'd0;
                m_data[d][t] = 32'd0;
            end
        end
        drive(0, CMD_NONE, 32'd0);
        drive(1, CMD_NONE, 32'd0);

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_d0_resp", 32'(if0.out_resp), 32'd0);
        check("rst_d0_data", if0.out_data, 32'd0);
        check("rst_d0_busy", 32'(if0.busy), 32'd0);
        check("rst_d1_busy", 32'(if1.busy), 32'd0);
        cmp_en = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(4);

        // Latency 1, back-to-back at the earliest acceptance cycle
        issue(0, "add_5_3",     CMD_ADD, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0008, 0);
        issue(0, "sub_under",   CMD_SUB, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000, 0);
        issue(0, "sub_equal",   CMD_SUB, 32'h0000_000F, 32'h0000_000F, 2'd1, 32'h0000_0000, 0);
        issue(0, "add_ovf",     CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 0);
        issue(0, "add_max",     CMD_ADD, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF, 0);
        issue(0, "shl_3",       CMD_SHL, 32'h0000_0001, 32'h0000_0023, 2'd1, 32'h0000_0008, 0);
        issue(0, "shr_31",      CMD_SHR, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 0);
        issue(0, "cmd3",        4'd3,    32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000, 0);
        idle(2);
        issue(0, "cmd15",       4'd15,   32'h0000_0007, 32'h0000_0007, 2'd2, 32'h0000_0000, 0);
        issue(0, "shl_0",       CMD_SHL, 32'h0000_1234, 32'h0000_0020, 2'd1, 32'h0000_1234, 0);
        issue(0, "sub_ok",      CMD_SUB, 32'h0000_0010, 32'h0000_0003, 2'd1, 32'h0000_000D, 0);
        idle(3);

        // Latency 4, commands presented while busy are dropped
        issue(1, "l4_add_drop", CMD_ADD, 32'h0000_0007, 32'h0000_0009, 2'd1, 32'h0000_0010, 2);
        idle(2);
        issue(1, "l4_shr_drop", CMD_SHR, 32'h0000_00F0, 32'h0000_0004, 2'd1, 32'h0000_000F, 1);
        issue(1, "l4_shl_b2b",  CMD_SHL, 32'h0000_0003, 32'h0000_0004, 2'd1, 32'h0000_0030, 0);
        idle(4);

        // Reset while waiting: outputs clear at once and no response follows
        n = cyc;
        model_req(1, n, CMD_ADD, 32'd1, 32'd2);
        drive(1, CMD_ADD, 32'd1);
        idle(1);
        drive(1, CMD_NONE, 32'd2);
        idle(1);
        drive(1, CMD_NONE, 32'd0);
        idle(1);
        reset_n = 1'b0;
        #1;
        check("rst_wait_busy", 32'(if1.busy), 32'd0);
        check("rst_wait_resp", 32'(if1.out_resp), 32'd0);
        check("rst_wait_data", if1.out_data, 32'd0);
        for (int d = 0; d < 2; d++) begin
            for (int t = cyc; t < MAXC; t++) begin
                m_resp[d][t] = 2'd0;
                m_data[d][t] = 32'd0;
                m_busy[d][t] = 1'b0;
            end
        end
        #1;
        idle(2);
        reset_n = 1'b1;
        idle(10);
        issue(1, "l4_after_rst", CMD_ADD, 32'h0000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002, 0);
        idle(3);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
